// File: rtl/pong_frame_scheduler_if.sv
// Signal bundle between the LCD timing generator / button synchroniser and the
// Pong frame scheduler, plus the committed game state seen by the renderer.
interface pong_frame_scheduler_if;
    // timing generator and buttons
    logic       i_data_enable;
    logic [8:0] i_y;
    logic       i_up_l;
    logic       i_dn_l;
    logic       i_up_r;
    logic       i_dn_r;
    // committed game state
    logic [8:0] o_paddle_l_y;
    logic [8:0] o_paddle_r_y;
    logic [8:0] o_ball_x;
    logic [8:0] o_ball_y;
    logic [3:0] o_score_l;
    logic [3:0] o_score_r;
    logic       o_busy;
    logic       o_frame_tick;
    logic       o_game_over;

    // master: timing/button source and state consumer
    modport master (
        output i_data_enable, i_y, i_up_l, i_dn_l, i_up_r, i_dn_r,
        input  o_paddle_l_y, o_paddle_r_y, o_ball_x, o_ball_y,
        input  o_score_l, o_score_r, o_busy, o_frame_tick, o_game_over
    );

    // slave: the scheduler itself
    modport slave (
        input  i_data_enable, i_y, i_up_l, i_dn_l, i_up_r, i_dn_r,
        output o_paddle_l_y, o_paddle_r_y, o_ball_x, o_ball_y,
        output o_score_l, o_score_r, o_busy, o_frame_tick, o_game_over
    );
endinterface

// File: rtl/pong_frame_scheduler.sv
// Per-frame Pong game-state update. Detects the end of the active frame from
// the LCD data-enable and row, runs a one-cycle-per-step update sequence on
// working registers, then commits everything to the output registers in one
// edge so the renderer never observes a partially updated frame.
module pong_frame_scheduler #(
    parameter int SCREEN_W     = 480,
    parameter int SCREEN_H     = 272,
    parameter int PADDLE_W     = 8,
    parameter int PADDLE_H     = 48,
    parameter int BALL_SIZE    = 8,
    parameter int LEFT_X       = 16,
    parameter int RIGHT_X      = 456,
    parameter int PADDLE_SPEED = 4,
    parameter int BALL_SPEED   = 2,
    parameter int WIN_SCORE    = 9
) (
    input  logic                   i_clk,
    input  logic                   i_rst,
    pong_frame_scheduler_if.slave  bus
);

    typedef enum logic [2:0] {
        IDLE,
        PADDLES,
        BALL,
        WALL,
        HIT,
        SCORE,
        COMMIT
    } state_t;

    // 10-bit signed working constants so underflow below zero is visible
    localparam logic signed [9:0] ZERO     = '0;
    localparam logic signed [9:0] PAD_SPD  = 10'(PADDLE_SPEED);
    localparam logic signed [9:0] PAD_MAX  = 10'(SCREEN_H - PADDLE_H);
    localparam logic signed [9:0] PAD_HGT  = 10'(PADDLE_H);
    localparam logic signed [9:0] BALL_SPD = 10'(BALL_SPEED);
    localparam logic signed [9:0] BALL_SZ  = 10'(BALL_SIZE);
    localparam logic signed [9:0] Y_MAX    = 10'(SCREEN_H - BALL_SIZE);
    localparam logic signed [9:0] X_MAX    = 10'(SCREEN_W - BALL_SIZE);
    localparam logic signed [9:0] L_FACE   = 10'(LEFT_X + PADDLE_W);
    localparam logic signed [9:0] L_BACK   = 10'(LEFT_X - BALL_SIZE);
    localparam logic signed [9:0] R_FACE   = 10'(RIGHT_X);
    localparam logic signed [9:0] R_STOP   = 10'(RIGHT_X - BALL_SIZE);

    localparam logic [8:0] CENTER_X = 9'((SCREEN_W - BALL_SIZE) / 2);
    localparam logic [8:0] CENTER_Y = 9'((SCREEN_H - BALL_SIZE) / 2);
    localparam logic [8:0] PAD_RST  = 9'((SCREEN_H - PADDLE_H) / 2);
    localparam logic [8:0] ROW_LAST = 9'(SCREEN_H - 1);
    localparam logic [3:0] WIN      = 4'(WIN_SCORE);

    state_t state;
    state_t state_nxt;

    // frame-end detection
    logic       de_q;
    logic       de_qq;
    logic [8:0] y_q;
    logic       frame_end;

    // working registers
    logic [8:0]        pl_w;
    logic [8:0]        pr_w;
    logic [8:0]        bx_w;
    logic [8:0]        by_w;
    logic              dx_w;
    logic              dy_w;
    logic [3:0]        sl_w;
    logic [3:0]        sr_w;
    logic signed [9:0] nx;
    logic signed [9:0] ny;
    logic              hit_w;

    // committed outputs
    logic [8:0] pl_q;
    logic [8:0] pr_q;
    logic [8:0] bx_q;
    logic [8:0] by_q;
    logic [3:0] sl_q;
    logic [3:0] sr_q;
    logic       tick_q;
    logic       go_q;

    // combinational step results
    logic [8:0]        pl_next;
    logic [8:0]        pr_next;
    logic signed [9:0] nx_ball;
    logic signed [9:0] ny_ball;
    logic signed [9:0] pl_s;
    logic signed [9:0] pr_s;
    logic              ovl_l;
    logic              ovl_r;
    logic              hit_l;
    logic              hit_r;
    logic              miss_l;
    logic              miss_r;

    // One paddle move with clamping; done in signed 10-bit so 0-4 clamps instead of wrapping
    function automatic logic [8:0] paddle_step(input logic [8:0] y, input logic up, input logic dn);
        logic signed [9:0] p;
        p = signed'({1'b0, y});
        if (up && !dn) begin
            p = p - PAD_SPD;
        end else if (dn && !up) begin
            p = p + PAD_SPD;
        end
        if (p < ZERO) begin
            p = ZERO;
        end else if (p > PAD_MAX) begin
            p = PAD_MAX;
        end
        return p[8:0];
    endfunction

    // Register DE and row so frame end is a single-cycle pulse on the DE fall at the last row
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            de_q  <= 1'b0;
            de_qq <= 1'b0;
            y_q   <= '0;
        end else begin
            de_q  <= bus.i_data_enable;
            de_qq <= de_q;
            y_q   <= bus.i_y;
        end
    end

    assign frame_end = de_qq & ~de_q & (y_q == ROW_LAST);

    // State register
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state: fixed one-cycle-per-step walk, started only from IDLE while the game runs
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (frame_end && !go_q) state_nxt = PADDLES;
            PADDLES: state_nxt = BALL;
            BALL:    state_nxt = WALL;
            WALL:    state_nxt = HIT;
            HIT:     state_nxt = SCORE;
            SCORE:   state_nxt = COMMIT;
            COMMIT:  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Step arithmetic: paddle moves, ball advance, paddle overlap, hit and miss tests
    always_comb begin
        pl_next = paddle_step(pl_w, bus.i_up_l, bus.i_dn_l);
        pr_next = paddle_step(pr_w, bus.i_up_r, bus.i_dn_r);
        nx_ball = dx_w ? signed'({1'b0, bx_w}) + BALL_SPD : signed'({1'b0, bx_w}) - BALL_SPD;
        ny_ball = dy_w ? signed'({1'b0, by_w}) + BALL_SPD : signed'({1'b0, by_w}) - BALL_SPD;
        pl_s    = signed'({1'b0, pl_w});
        pr_s    = signed'({1'b0, pr_w});
        ovl_l   = (ny + BALL_SZ > pl_s) && (ny < pl_s + PAD_HGT);
        ovl_r   = (ny + BALL_SZ > pr_s) && (ny < pr_s + PAD_HGT);
        hit_l   = !dx_w && (nx <= L_FACE) && (nx > L_BACK) && ovl_l;
        hit_r   = dx_w && (nx + BALL_SZ >= R_FACE) && ovl_r;
        miss_l  = !hit_w && (nx <= ZERO);
        miss_r  = !hit_w && (nx >= X_MAX);
    end

    // Working registers: each state updates only its own slice of the game state
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            pl_w  <= PAD_RST;
            pr_w  <= PAD_RST;
            bx_w  <= CENTER_X;
            by_w  <= CENTER_Y;
            dx_w  <= 1'b1;
            dy_w  <= 1'b1;
            sl_w  <= '0;
            sr_w  <= '0;
            nx    <= '0;
            ny    <= '0;
            hit_w <= 1'b0;
        end else begin
            case (state)
                PADDLES: begin
                    pl_w <= pl_next;
                    pr_w <= pr_next;
                end
                BALL: begin
                    nx <= nx_ball;
                    ny <= ny_ball;
                end
                WALL: begin
                    if (ny <= ZERO) begin
                        ny   <= ZERO;
                        dy_w <= 1'b1;
                    end else if (ny >= Y_MAX) begin
                        ny   <= Y_MAX;
                        dy_w <= 1'b0;
                    end
                end
                HIT: begin
                    hit_w <= hit_l | hit_r;
                    if (hit_l) begin
                        nx   <= L_FACE;
                        dx_w <= 1'b1;
                    end else if (hit_r) begin
                        nx   <= R_STOP;
                        dx_w <= 1'b0;
                    end
                end
                SCORE: begin
                    if (miss_l) begin
                        if (sr_w < WIN) sr_w <= sr_w + 4'd1;
                        bx_w <= CENTER_X;
                        by_w <= CENTER_Y;
                        dx_w <= 1'b0;
                    end else if (miss_r) begin
                        if (sl_w < WIN) sl_w <= sl_w + 4'd1;
                        bx_w <= CENTER_X;
                        by_w <= CENTER_Y;
                        dx_w <= 1'b1;
                    end else begin
                        bx_w <= nx[8:0];
                        by_w <= ny[8:0];
                    end
                end
                default: ;
            endcase
        end
    end

    // Output registers: single commit edge, tick follows it, game over is sticky
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            pl_q   <= PAD_RST;
            pr_q   <= PAD_RST;
            bx_q   <= CENTER_X;
            by_q   <= CENTER_Y;
            sl_q   <= '0;
            sr_q   <= '0;
            tick_q <= 1'b0;
            go_q   <= 1'b0;
        end else begin
            tick_q <= (state == COMMIT);
            if (state == COMMIT) begin
                pl_q <= pl_w;
                pr_q <= pr_w;
                bx_q <= bx_w;
                by_q <= by_w;
                sl_q <= sl_w;
                sr_q <= sr_w;
                if ((sl_w == WIN) || (sr_w == WIN)) go_q <= 1'b1;
            end
        end
    end

    assign bus.o_paddle_l_y = pl_q;
    assign bus.o_paddle_r_y = pr_q;
    assign bus.o_ball_x     = bx_q;
    assign bus.o_ball_y     = by_q;
    assign bus.o_score_l    = sl_q;
    assign bus.o_score_r    = sr_q;
    assign bus.o_busy       = (state != IDLE);
    assign bus.o_frame_tick = tick_q;
    assign bus.o_game_over  = go_q;

endmodule

// File: doc/pong_frame_scheduler.md
# pong_frame_scheduler

Sequences the per-frame game-state update for the Pong datapath. Runs in the LCD pixel clock domain alongside the LCD driver. It detects the end of the active frame from the driver's data-enable and row outputs, then runs a fixed multi-cycle update: paddles, ball motion, wall bounce, paddle hit, scoring. It publishes double-buffered positions and scores, so the pixel renderer never sees a half-updated frame.

## Interface
Parameters:
- SCREEN_W, 480, active columns
- SCREEN_H, 272, active rows
- PADDLE_W, 8, paddle width in pixels
- PADDLE_H, 48, paddle height in pixels
- BALL_SIZE, 8, ball edge length in pixels
- LEFT_X, 16, left paddle left edge x
- RIGHT_X, 456, right paddle left edge x
- PADDLE_SPEED, 4, paddle pixels per frame
- BALL_SPEED, 2, ball pixels per frame on each axis
- WIN_SCORE, 9, score that ends the game

Ports:
- i_clk  in  1  pixel clock, the same clock that drives the LCD panel
- i_rst  in  1  reset; synchronous and active-high
- i_data_enable  in  1  LCD data-enable from the timing generator
- i_y  in  9  current LCD row from the timing generator
- i_up_l, i_dn_l, i_up_r, i_dn_r  in  1 each  paddle buttons, already synchronised and level-sensitive
- o_paddle_l_y, o_paddle_r_y  out  9 each  paddle top edge y
- o_ball_x, o_ball_y  out  9 each  ball top-left corner
- o_score_l, o_score_r  out  4 each  scores, 0..WIN_SCORE
- o_busy  out  1  high while the update sequence runs
- o_frame_tick  out  1  one-cycle pulse when new outputs are committed
- o_game_over  out  1  sticky once either score reaches WIN_SCORE

## Operation
- Frame end: registered i_data_enable goes 1→0 while i_y == SCREEN_H-1. This produces a single-cycle frame_end.
- FSM states: IDLE → PADDLES → BALL → WALL → HIT → SCORE → COMMIT → IDLE. Each state lasts one cycle. All work is done on internal working registers.
- IDLE: on frame_end with o_game_over low, go to PADDLES. frame_end in any other state is ignored, with no queuing.
- PADDLES: each paddle moves -PADDLE_SPEED when up is pressed alone, +PADDLE_SPEED when down is pressed alone. Both or neither pressed means no move. The result is clamped to [0, SCREEN_H-PADDLE_H]. Arithmetic is 10-bit signed so underflow is detected and never wraps.
- BALL: next_x = x ± BALL_SPEED and next_y = y ± BALL_SPEED, with direction bits dx and dy (1 = +). Uses 10-bit signed intermediates.
- WALL: if next_y ≤ 0, set y=0 and dy=1. If next_y ≥ SCREEN_H-BALL_SIZE, set y=SCREEN_H-BALL_SIZE and dy=0.
- HIT, left paddle: applies when dx=0, next_x ≤ LEFT_X+PADDLE_W, next_x > LEFT_X-BALL_SIZE, and ball_y+BALL_SIZE > paddle_l_y and ball_y < paddle_l_y+PADDLE_H. Then x=LEFT_X+PADDLE_W and dx=1.
- HIT, right paddle: the mirror case. Applies when dx=1, next_x+BALL_SIZE ≥ RIGHT_X, with the same vertical overlap test against paddle_r_y. Then x=RIGHT_X-BALL_SIZE and dx=0.
- SCORE, left miss: next_x ≤ 0 without a hit. score_r increments, the ball resets to ((SCREEN_W-BALL_SIZE)/2, (SCREEN_H-BALL_SIZE)/2) = (236,132), and dx=0 (serve toward the side that conceded). dy is unchanged.
- SCORE, right miss: next_x ≥ SCREEN_W-BALL_SIZE without a hit. score_l increments, the ball resets to center, and dx=1.
- A hit has priority over a miss in the same frame.
- COMMIT: copy the working registers to the output registers. Pulse o_frame_tick. Set o_game_over if either score equals WIN_SCORE. Scores saturate at WIN_SCORE.
- o_game_over freezes all outputs until i_rst.

## Timing
- Reset values on the cycle after i_rst is sampled high:
  - state IDLE; o_busy=0; o_frame_tick=0; o_game_over=0
  - o_paddle_l_y = o_paddle_r_y = 112
  - o_ball_x=236, o_ball_y=132, dx=1, dy=1
  - scores 0
- Reset mid-sequence: the working registers are discarded, the outputs take their reset values, and the FSM returns to IDLE.
- frame_end is detected at cycle 0, which is the first cycle DE is sampled low.
- Update pipeline:
  - PADDLES runs at cycle 1 and COMMIT at cycle 6.
  - New outputs are visible from cycle 7.
  - o_frame_tick is high during cycle 7 only.
  - o_busy is high in cycles 1–6.
- Outputs are stable at all times except the single COMMIT edge, which always falls inside blanking.
- Buttons are sampled only in PADDLES.

## Test plan
- Reset and hold 3 frames, no buttons: after frame 1 the ball is at (238,134), paddles stay at 112, and o_frame_tick pulses exactly once per frame, 7 cycles after DE falls at row 271.
- Hold i_up_l for 40 frames: o_paddle_l_y steps by 4 per frame, reaches 0 after 28 frames, then stays at 0. Pressing i_up_r and i_dn_r together leaves o_paddle_r_y at 112.
- Force the ball to (300,2) with dy=0 via a prior sequence: the next commit gives y=0 and dy=1, and the frame after gives y=2.
- Ball moving left at x=26 with paddle_l_y overlapping it: the commit gives x=24 and dx=1, and the score is unchanged.
- Ball moving left with the left paddle out of the way, reaching x ≤ 0: o_score_r goes 0→1, the ball resets to (236,132) with dx=0. Repeat to 9: o_game_over=1, and subsequent frame_ends produce no o_frame_tick.
- Assert i_rst during BALL: the next cycle shows all outputs at reset values and o_busy=0. A DE falling edge at a row other than 271 produces no sequence.
